sd_card_cmd_responder: RTL and testbench
========================================

SD_CARD_CMD_RESPONDER -- requirements
Module: sd_card_cmd_responder

Interface
REQ-001 Parameter NCR, default 2, range 2..64: minimum clock cycles of response gap in WAIT_RSP.
REQ-002 SD_CLK_IN  input  1  single clock; all sampling and driving on its rising edge.
REQ-003 RST_IN_N  input  1  reset, asynchronous, active-low.
REQ-004 cmd_dat_i  input  1  CMD line sample.
REQ-005 cmd_out_o  output  1  CMD line drive value.
REQ-006 cmd_oe_o  output  1  CMD drive enable; 0 = line released.
REQ-007 ABORT_IN  input  1  synchronous abort to IDLE.
REQ-008 CMD_VALID_OUT  output  1  one-cycle pulse: good command received.
REQ-009 CMD_INDEX_OUT  output  6  received command index, held until next CMD_VALID_OUT.
REQ-010 CMD_ARG_OUT  output  32  received argument, held likewise.
REQ-011 CRC_ERR_OUT  output  1  one-cycle pulse: CRC7 mismatch.
REQ-012 FRAME_ERR_OUT  output  1  one-cycle pulse: transmission bit 0 or end bit 0.
REQ-013 RSP_VALID_IN  input  1  response fields ready; level, sampled in WAIT_RSP.
REQ-014 RSP_NONE_IN  input  1  command needs no response; sampled in WAIT_RSP.
REQ-015 RSP_LONG_IN  input  1  1 = 136-bit response, 0 = 48-bit.
REQ-016 RSP_NOCRC_IN  input  1  1 = send CRC field as 7'h7F (short only).
REQ-017 RSP_INDEX_IN  input  6  short-response index field.
REQ-018 RSP_ARG_IN  input  32  short-response payload.
REQ-019 RSP_DATA_IN  input  128  long-response payload; bits [127:8] sent.
REQ-020 RSP_ACK_OUT  output  1  one-cycle pulse: response fully transmitted.
REQ-021 BUSY_OUT  output  1  1 in every state except IDLE.

Function
REQ-022 States SHALL be IDLE, RX, CHECK, WAIT_RSP, TX; ABORT_IN=1 forces IDLE next edge from any state, no pulses emitted, cmd_oe_o=0.
REQ-023 IDLE: cmd_oe_o=0; cmd_dat_i=0 sampled -> RX, bit counter=1 (start bit stored as bit 47).
REQ-024 RX: store one bit per cycle MSB-first into 48-bit shift register; after bit 47 (end bit) sampled -> CHECK.
REQ-025 CRC7 SHALL use polynomial x^7+x^3+1, init 0, over frame bits 47..8 (40 bits).
REQ-026 CHECK (1 cycle): bit46=0 or bit0=0 -> FRAME_ERR_OUT pulse, -> IDLE; else CRC mismatch vs bits 7..1 -> CRC_ERR_OUT pulse, -> IDLE; else CMD_VALID_OUT pulse, CMD_INDEX_OUT=bits 45..40, CMD_ARG_OUT=bits 39..8, -> WAIT_RSP; FRAME_ERR takes priority.
REQ-027 WAIT_RSP: 8-bit gap counter cleared on entry, increments saturating at 255; cmd_oe_o=0.
REQ-028 WAIT_RSP: RSP_NONE_IN=1 -> IDLE, no RSP_ACK_OUT; takes priority over RSP_VALID_IN.
REQ-029 WAIT_RSP: RSP_VALID_IN=1 and counter>=NCR-1 -> TX; RSP_* fields latched at that edge; later changes ignored.
REQ-030 TX short frame, 48 bits: 0, 0, RSP_INDEX_IN, RSP_ARG_IN, CRC7 over first 40 bits (or 7'h7F if RSP_NOCRC_IN), 1.
REQ-031 TX long frame, 136 bits: 0, 0, 6'b111111, RSP_DATA_IN[127:8], CRC7 over RSP_DATA_IN[127:8], 1; RSP_NOCRC_IN ignored.
REQ-032 TX: cmd_oe_o=1, one bit per cycle MSB-first; cmd_dat_i ignored; after end bit -> IDLE with RSP_ACK_OUT pulse and cmd_oe_o=0 same cycle.
REQ-033 Latency: with RSP_VALID_IN held 1, start bit on cmd_out_o in cycle NCR+2 after the edge sampling command end bit.
REQ-034 cmd_out_o SHALL be 1 whenever cmd_oe_o=0.
REQ-035 Start bit detected in IDLE the cycle after RSP_ACK_OUT SHALL be accepted (back-to-back commands).

Reset
REQ-036 RST_IN_N=0 SHALL immediately force IDLE, cmd_oe_o=0, cmd_out_o=1, all pulses 0, CMD_INDEX_OUT=0, CMD_ARG_OUT=0, BUSY_OUT=0, counters and CRC 0, including mid-RX or mid-TX.

Verification
REQ-037 CMD0 frame 0x400000000095 -> CMD_VALID_OUT pulse, index 0, arg 0; RSP_NONE_IN=1 -> IDLE, cmd_oe_o never 1.
REQ-038 CMD8 frame 0x48000001AA87, RSP_VALID_IN=1, index 8, arg 0x1AA -> cmd_out_o bits 0x08000001AA13 starting cycle NCR+2, RSP_ACK_OUT after end bit.
REQ-039 CMD8 frame with CRC byte 0x85 -> CRC_ERR_OUT pulse, no CMD_VALID_OUT, returns IDLE.
REQ-040 Frame 0x08000001AA13 (transmission bit 0) -> FRAME_ERR_OUT pulse only.
REQ-041 Long response, RSP_DATA_IN=128'h0123...EF -> 136 bits, cmd_oe_o high exactly 136 cycles, CRC7 matches model.
REQ-042 RST_IN_N low at TX bit 20 -> cmd_oe_o=0 asynchronously, no RSP_ACK_OUT; next CMD0 accepted normally.

Source files
------------

// File: rtl/sd_card_cmd_responder.sv
// rtl/sd_card_cmd_responder.sv - SD CMD-line command receiver with CRC7 check and 48/136-bit response transmitter
module sd_card_cmd_responder #(
    parameter int NCR = 2
) (
    input  logic         SD_CLK_IN,
    input  logic         RST_IN_N,
    input  logic         cmd_dat_i,
    output logic         cmd_out_o,
    output logic         cmd_oe_o,
    input  logic         ABORT_IN,
    output logic         CMD_VALID_OUT,
    output logic [5:0]   CMD_INDEX_OUT,
    output logic [31:0]  CMD_ARG_OUT,
    output logic         CRC_ERR_OUT,
    output logic         FRAME_ERR_OUT,
    input  logic         RSP_VALID_IN,
    input  logic         RSP_NONE_IN,
    input  logic         RSP_LONG_IN,
    input  logic         RSP_NOCRC_IN,
    input  logic [5:0]   RSP_INDEX_IN,
    input  logic [31:0]  RSP_ARG_IN,
    input  logic [127:0] RSP_DATA_IN,
    output logic         RSP_ACK_OUT,
    output logic         BUSY_OUT
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RX    = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_TX    = 3'd4;

    logic [2:0]   state;
    logic [5:0]   bit_cnt;
    logic [47:0]  rx_sr;
    logic [6:0]   crc;
    logic [7:0]   gap_cnt;
    logic [135:0] tx_sr;
    logic [7:0]   tx_cnt;
    logic         tx_long;
    logic [135:0] tx_frame;
    logic [6:0]   short_crc;
    logic         unused_bits;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic d);
        logic fb;
        fb = c[6] ^ d;
        return {c[5:3], c[2] ^ fb, c[1:0], fb};
    endfunction

    // Leading zeros leave a zero-initialised CRC untouched, so short frames are zero-padded to 120 bits.
    function automatic logic [6:0] crc7_calc(input logic [119:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 119; i >= 0; i--) begin
            c = crc7_step(c, d[i]);
        end
        return c;
    endfunction

    always_comb begin
        short_crc = RSP_NOCRC_IN ? 7'h7F : crc7_calc({80'd0, 2'b00, RSP_INDEX_IN, RSP_ARG_IN});
        if (RSP_LONG_IN) begin
            tx_frame = {2'b00, 6'h3F, RSP_DATA_IN[127:8], crc7_calc(RSP_DATA_IN[127:8]), 1'b1};
        end else begin
            tx_frame = {2'b00, RSP_INDEX_IN, RSP_ARG_IN, short_crc, 1'b1, 88'd0};
        end
    end

    assign unused_bits = ^{RSP_DATA_IN[7:0], rx_sr[47]};
    assign cmd_oe_o    = (state == S_TX);
    assign cmd_out_o   = (state == S_TX) ? tx_sr[135] : 1'b1;
    assign BUSY_OUT    = (state != S_IDLE);

    always_ff @(posedge SD_CLK_IN or negedge RST_IN_N) begin
        if (!RST_IN_N) begin
            state         <= S_IDLE;
            bit_cnt       <= '0;
            rx_sr         <= '0;
            crc           <= '0;
            gap_cnt       <= '0;
            tx_sr         <= '0;
            tx_cnt        <= '0;
            tx_long       <= 1'b0;
            CMD_VALID_OUT <= 1'b0;
            CMD_INDEX_OUT <= '0;
            CMD_ARG_OUT   <= '0;
            CRC_ERR_OUT   <= 1'b0;
            FRAME_ERR_OUT <= 1'b0;
            RSP_ACK_OUT   <= 1'b0;
        end else begin
            CMD_VALID_OUT <= 1'b0;
            CRC_ERR_OUT   <= 1'b0;
            FRAME_ERR_OUT <= 1'b0;
            RSP_ACK_OUT   <= 1'b0;
            if (ABORT_IN) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (!cmd_dat_i) begin
                            state   <= S_RX;
                            bit_cnt <= 6'd1;
                            rx_sr   <= '0;
                            crc     <= '0;
                        end
                    end
                    S_RX: begin
                        rx_sr <= {rx_sr[46:0], cmd_dat_i};
                        if (bit_cnt <= 6'd39) begin
                            crc <= crc7_step(crc, cmd_dat_i);
                        end
                        if (bit_cnt == 6'd47) begin
                            state <= S_CHECK;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                    S_CHECK: begin
                        if (!rx_sr[46] || !rx_sr[0]) begin
                            FRAME_ERR_OUT <= 1'b1;
                            state         <= S_IDLE;
                        end else if (crc != rx_sr[7:1]) begin
                            CRC_ERR_OUT <= 1'b1;
                            state       <= S_IDLE;
                        end else begin
                            CMD_VALID_OUT <= 1'b1;
                            CMD_INDEX_OUT <= rx_sr[45:40];
                            CMD_ARG_OUT   <= rx_sr[39:8];
                            gap_cnt       <= '0;
                            state         <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (RSP_NONE_IN) begin
                            state <= S_IDLE;
                        end else if (RSP_VALID_IN && gap_cnt >= 8'(NCR - 1)) begin
                            tx_sr   <= tx_frame;
                            tx_long <= RSP_LONG_IN;
                            tx_cnt  <= '0;
                            state   <= S_TX;
                        end else if (gap_cnt != 8'hFF) begin
                            gap_cnt <= gap_cnt + 8'd1;
                        end
                    end
                    S_TX: begin
                        if (tx_cnt == (tx_long ? 8'd135 : 8'd47)) begin
                            RSP_ACK_OUT <= 1'b1;
                            state       <= S_IDLE;
                        end else begin
                            tx_sr  <= {tx_sr[134:0], 1'b0};
                            tx_cnt <= tx_cnt + 8'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// tb/tb_sd_card_cmd_responder.sv - directed and randomized bench for sd_card_cmd_responder
module tb_sd_card_cmd_responder;

    localparam int NCR = 3;

    logic         SD_CLK_IN = 1'b0;
    logic         RST_IN_N;
    logic         cmd_dat_i;
    logic         cmd_out_o;
    logic         cmd_oe_o;
    logic         ABORT_IN;
    logic         CMD_VALID_OUT;
    logic [5:0]   CMD_INDEX_OUT;
    logic [31:0]  CMD_ARG_OUT;
    logic         CRC_ERR_OUT;
    logic         FRAME_ERR_OUT;
    logic         RSP_VALID_IN;
    logic         RSP_NONE_IN;
    logic         RSP_LONG_IN;
    logic         RSP_NOCRC_IN;
    logic [5:0]   RSP_INDEX_IN;
    logic [31:0]  RSP_ARG_IN;
    logic [127:0] RSP_DATA_IN;
    logic         RSP_ACK_OUT;
    logic         BUSY_OUT;

    int vectors = 0;
    int miscompares = 0;

    sd_card_cmd_responder #(.NCR(NCR)) dut (
        .SD_CLK_IN    (SD_CLK_IN),
        .RST_IN_N     (RST_IN_N),
        .cmd_dat_i    (cmd_dat_i),
        .cmd_out_o    (cmd_out_o),
        .cmd_oe_o     (cmd_oe_o),
        .ABORT_IN     (ABORT_IN),
        .CMD_VALID_OUT(CMD_VALID_OUT),
        .CMD_INDEX_OUT(CMD_INDEX_OUT),
        .CMD_ARG_OUT  (CMD_ARG_OUT),
        .CRC_ERR_OUT  (CRC_ERR_OUT),
        .FRAME_ERR_OUT(FRAME_ERR_OUT),
        .RSP_VALID_IN (RSP_VALID_IN),
        .RSP_NONE_IN  (RSP_NONE_IN),
        .RSP_LONG_IN  (RSP_LONG_IN),
        .RSP_NOCRC_IN (RSP_NOCRC_IN),
        .RSP_INDEX_IN (RSP_INDEX_IN),
        .RSP_ARG_IN   (RSP_ARG_IN),
        .RSP_DATA_IN  (RSP_DATA_IN),
        .RSP_ACK_OUT  (RSP_ACK_OUT),
        .BUSY_OUT     (BUSY_OUT)
    );

    always #5 SD_CLK_IN = ~SD_CLK_IN;

    // CRC7 as the remainder of msg * x^7 modulo x^7+x^3+1 (long division, MSB first).
    function automatic logic [6:0] m_crc7(input logic [119:0] msg, input int nbits);
        logic [126:0] r;
        r = {msg, 7'b0};
        for (int i = nbits + 6; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    function automatic logic [47:0] cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
        return {2'b01, idx, arg, m_crc7({80'd0, 2'b01, idx, arg}, 40), 1'b1};
    endfunction

    function automatic logic [135:0] rsp_short(input logic [5:0] idx, input logic [31:0] arg,
                                               input logic nocrc);
        logic [6:0] c;
        c = nocrc ? 7'h7F : m_crc7({80'd0, 2'b00, idx, arg}, 40);
        return {88'd0, 2'b00, idx, arg, c, 1'b1};
    endfunction

    function automatic logic [135:0] rsp_long(input logic [127:0] data);
        return {2'b00, 6'h3F, data[127:8], m_crc7(data[127:8], 120), 1'b1};
    endfunction

    task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge SD_CLK_IN);
        #1;
    endtask

    task automatic send_cmd(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            cmd_dat_i = f[i];
            step();
        end
        cmd_dat_i = 1'b1;
    endtask

    task automatic scramble_rsp();
        RSP_INDEX_IN = 6'($urandom);
        RSP_ARG_IN   = $urandom;
        RSP_DATA_IN  = {$urandom, $urandom, $urandom, $urandom};
        RSP_NOCRC_IN = 1'($urandom);
        RSP_LONG_IN  = 1'($urandom);
    endtask

    task automatic capture(output logic [135:0] bits, output int len);
        bits = '0;
        len  = 0;
        while (cmd_oe_o === 1'b1 && len < 200) begin
            bits = {bits[134:0], cmd_out_o};
            len++;
            if (len == 1) scramble_rsp();
            step();
        end
    endtask

    task automatic exchange(input string tag, input logic [47:0] f, input logic [5:0] eidx,
                            input logic [31:0] earg, input logic [135:0] erx, input int elen);
        logic [135:0] bits;
        int len;
        send_cmd(f);
        step();
        chk({tag, "_valid"}, CMD_VALID_OUT, 1'b1);
        chk({tag, "_index"}, CMD_INDEX_OUT, eidx);
        chk({tag, "_arg"}, CMD_ARG_OUT, earg);
        repeat (NCR - 1) step();
        chk({tag, "_gap_oe"}, cmd_oe_o, 1'b0);
        step();
        chk({tag, "_start_oe"}, cmd_oe_o, 1'b1);
        capture(bits, len);
        chk({tag, "_len"}, len, elen);
        chk({tag, "_bits"}, bits, erx);
        chk({tag, "_ack"}, RSP_ACK_OUT, 1'b1);
    endtask

    initial begin
        logic [135:0] exp;
        logic [5:0]   idx;
        logic [31:0]  arg;
        logic         seen_oe;
        logic         seen_ack;

        RST_IN_N = 1'b1;
        cmd_dat_i = 1'b1;
        ABORT_IN = 1'b0;
        RSP_VALID_IN = 1'b1;
        RSP_NONE_IN = 1'b1;
        RSP_LONG_IN = 1'b0;
        RSP_NOCRC_IN = 1'b0;
        RSP_INDEX_IN = '0;
        RSP_ARG_IN = '0;
        RSP_DATA_IN = '0;
        #2 RST_IN_N = 1'b0;
        #1;
        chk("rst_oe", cmd_oe_o, 1'b0);
        chk("rst_out", cmd_out_o, 1'b1);
        chk("rst_busy", BUSY_OUT, 1'b0);
        chk("rst_pulses", {CMD_VALID_OUT, CRC_ERR_OUT, FRAME_ERR_OUT, RSP_ACK_OUT}, 4'b0);
        chk("rst_fields", {CMD_INDEX_OUT, CMD_ARG_OUT}, 38'd0);
        step();
        RST_IN_N = 1'b1;
        step();

        // CMD0 with no response; NONE wins over VALID
        send_cmd(48'h400000000095);
        step();
        chk("cmd0_valid", CMD_VALID_OUT, 1'b1);
        chk("cmd0_index", CMD_INDEX_OUT, 6'd0);
        chk("cmd0_arg", CMD_ARG_OUT, 32'd0);
        seen_oe = 1'b0;
        repeat (6) begin
            step();
            seen_oe |= cmd_oe_o;
        end
        chk("cmd0_no_oe", seen_oe, 1'b0);
        chk("cmd0_idle", BUSY_OUT, 1'b0);

        // CMD8 / R7
        RSP_NONE_IN = 1'b0;
        RSP_LONG_IN = 1'b0;
        RSP_NOCRC_IN = 1'b0;
        RSP_INDEX_IN = 6'd8;
        RSP_ARG_IN = 32'h1AA;
        exchange("cmd8", 48'h48000001AA87, 6'd8, 32'h1AA, 136'h08000001AA13, 48);
        step();
        chk("cmd8_ack_pulse", RSP_ACK_OUT, 1'b0);

        send_cmd(48'h48000001AA85);
        step();
        chk("crc_err", {CRC_ERR_OUT, FRAME_ERR_OUT, CMD_VALID_OUT}, 3'b100);
        step();
        chk("crc_idle", {BUSY_OUT, CRC_ERR_OUT}, 2'b00);

        send_cmd(48'h08000001AA13);
        step();
        chk("frame_err", {CRC_ERR_OUT, FRAME_ERR_OUT, CMD_VALID_OUT}, 3'b010);
        chk("frame_index_held", CMD_INDEX_OUT, 6'd8);
        step();
        chk("frame_idle", BUSY_OUT, 1'b0);

        RSP_LONG_IN = 1'b1;
        RSP_NOCRC_IN = 1'b1;
        RSP_DATA_IN = 128'h0123456789ABCDEF0123456789ABCDEF;
        exp = rsp_long(RSP_DATA_IN);
        exchange("long", cmd_frame(6'd2, 32'd0), 6'd2, 32'd0, exp, 136);

        // back-to-back randomized commands with fields scrambled once TX starts
        for (int k = 0; k < 10; k++) begin
            idx = 6'($urandom);
            arg = $urandom;
            RSP_LONG_IN = 1'($urandom_range(0, 1));
            RSP_NOCRC_IN = 1'($urandom_range(0, 1));
            RSP_INDEX_IN = 6'($urandom);
            RSP_ARG_IN = $urandom;
            RSP_DATA_IN = {$urandom, $urandom, $urandom, $urandom};
            exp = RSP_LONG_IN ? rsp_long(RSP_DATA_IN)
                              : rsp_short(RSP_INDEX_IN, RSP_ARG_IN, RSP_NOCRC_IN);
            exchange($sformatf("rand%0d", k), cmd_frame(idx, arg), idx, arg, exp,
                     RSP_LONG_IN ? 136 : 48);
        end

        // abort in the middle of a command
        for (int i = 47; i >= 38; i--) begin
            cmd_dat_i = cmd_frame(6'd17, 32'h55)[i];
            step();
        end
        cmd_dat_i = 1'b1;
        ABORT_IN = 1'b1;
        step();
        ABORT_IN = 1'b0;
        chk("abort_idle", BUSY_OUT, 1'b0);
        repeat (4) step();
        chk("abort_no_pulse", {CMD_VALID_OUT, CRC_ERR_OUT, FRAME_ERR_OUT, BUSY_OUT}, 4'b0);

        // reset at TX bit 20
        RSP_LONG_IN = 1'b0;
        RSP_NOCRC_IN = 1'b0;
        RSP_INDEX_IN = 6'd8;
        RSP_ARG_IN = 32'h1AA;
        send_cmd(48'h48000001AA87);
        step();
        repeat (NCR - 1) step();
        step();
        repeat (20) step();
        chk("pre_rst_oe", cmd_oe_o, 1'b1);
        RST_IN_N = 1'b0;
        #1;
        chk("midtx_rst_oe", cmd_oe_o, 1'b0);
        chk("midtx_rst_out", cmd_out_o, 1'b1);
        chk("midtx_rst_state", {BUSY_OUT, CMD_INDEX_OUT, CMD_ARG_OUT}, 39'd0);
        step();
        RST_IN_N = 1'b1;
        seen_ack = 1'b0;
        seen_oe = 1'b0;
        repeat (40) begin
            step();
            seen_ack |= RSP_ACK_OUT;
            seen_oe |= cmd_oe_o;
        end
        chk("midtx_no_ack", {seen_ack, seen_oe}, 2'b00);
        RSP_NONE_IN = 1'b1;
        send_cmd(48'h400000000095);
        step();
        chk("post_rst_cmd0", {CMD_VALID_OUT, CMD_INDEX_OUT, CMD_ARG_OUT}, {1'b1, 38'd0});
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
